// File: rtl/frac_dec_accumulator.sv
// rtl/frac_dec_accumulator.sv - accumulate-and-dump output stage of a polyphase decimator branch
// Sums NUM_TAPS products, then rounds, saturates and registers one DATA_WIDTH sample.
module frac_dec_accumulator #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_TAPS   = 4,
   parameter int FRAC_BITS  = 15,
   parameter int GUARD_BITS = 8,
   localparam int PH_W      = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear,
   input  logic                    prod_valid,
   input  logic [2*DATA_WIDTH-1:0] product,
   output logic [DATA_WIDTH-1:0]   acc_out,
   output logic                    out_valid,
   output logic                    sat_flag,
   output logic [PH_W-1:0]         phase
);

   localparam int ACC_W = 2*DATA_WIDTH + GUARD_BITS;
   localparam int RND_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
   localparam logic signed [ACC_W-1:0] ROUND_C = (FRAC_BITS > 0) ? (ACC_W'(1) << RND_SH) : '0;
   localparam logic signed [ACC_W-1:0] MAX_C = ACC_W'((64'sd1 <<< (DATA_WIDTH-1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] MIN_C = ACC_W'(-(64'sd1 <<< (DATA_WIDTH-1)));
   localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_TAPS - 1);

   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [PH_W-1:0]          phase_q, phase_d;
   logic [DATA_WIDTH-1:0]    acc_out_q, acc_out_d;
   logic                     out_valid_q, out_valid_d;
   logic                     sat_flag_q, sat_flag_d;

   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  sum;
   logic signed [ACC_W-1:0]  rounded;
   logic signed [ACC_W-1:0]  shifted;

   always_comb begin
      prod_ext = {{GUARD_BITS{product[2*DATA_WIDTH-1]}}, product};
      // phase 0 starts a fresh sample, so the stale acc from the last dump is dropped here
      sum      = (phase_q == '0) ? prod_ext : acc_q + prod_ext;
      rounded  = sum + ROUND_C;
      shifted  = rounded >>> FRAC_BITS;

      phase_d     = phase_q;
      acc_d       = acc_q;
      acc_out_d   = acc_out_q;
      out_valid_d = 1'b0;
      sat_flag_d  = 1'b0;

      if (clear) begin
         phase_d = '0;
         acc_d   = '0;
      end else if (prod_valid) begin
         acc_d = sum;
         if (phase_q == LAST_PH) begin
            phase_d     = '0;
            out_valid_d = 1'b1;
            if (shifted > MAX_C) begin
               acc_out_d  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
               sat_flag_d = 1'b1;
            end else if (shifted < MIN_C) begin
               acc_out_d  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
               sat_flag_d = 1'b1;
            end else begin
               acc_out_d  = shifted[DATA_WIDTH-1:0];
            end
         end else begin
            phase_d = phase_q + PH_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q       <= '0;
         phase_q     <= '0;
         acc_out_q   <= '0;
         out_valid_q <= 1'b0;
         sat_flag_q  <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         phase_q     <= phase_d;
         acc_out_q   <= acc_out_d;
         out_valid_q <= out_valid_d;
         sat_flag_q  <= sat_flag_d;
      end
   end

   assign acc_out   = acc_out_q;
   assign out_valid = out_valid_q;
   assign sat_flag  = sat_flag_q;
   assign phase     = phase_q;

endmodule

// File: tb/tb_frac_dec_accumulator.sv
// tb/tb_frac_dec_accumulator.sv - scoreboard bench for frac_dec_accumulator
// Covers a 4-tap instance and a 1-tap instance for single-sample rounding.
module tb_frac_dec_accumulator;

   typedef struct {
      logic [15:0] d;
      logic        s;
      int          c;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        clear = 1'b0;
   logic        prod_valid = 1'b0;
   logic [31:0] product = '0;
   logic [15:0] acc_out;
   logic        out_valid;
   logic        sat_flag;
   logic [1:0]  phase;

   logic        prod_valid1 = 1'b0;
   logic [31:0] product1 = '0;
   logic [15:0] acc_out1;
   logic        out_valid1;
   logic        sat_flag1;
   logic [0:0]  phase1;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   exp_t sb[$];
   exp_t sb1[$];

   frac_dec_accumulator #(.DATA_WIDTH(16), .NUM_TAPS(4), .FRAC_BITS(15), .GUARD_BITS(8)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .prod_valid(prod_valid), .product(product),
      .acc_out(acc_out), .out_valid(out_valid), .sat_flag(sat_flag), .phase(phase)
   );

   frac_dec_accumulator #(.DATA_WIDTH(16), .NUM_TAPS(1), .FRAC_BITS(15), .GUARD_BITS(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .clear(1'b0), .prod_valid(prod_valid1), .product(product1),
      .acc_out(acc_out1), .out_valid(out_valid1), .sat_flag(sat_flag1), .phase(phase1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : mon0
      exp_t e;
      if (rst_n) begin
         total++;
         if (out_valid) begin
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_pulse cyc=%0d acc_out=%h sat=%b", cyc, acc_out, sat_flag);
            end else begin
               e = sb.pop_front();
               if (acc_out !== e.d || sat_flag !== e.s || cyc !== e.c) begin
                  bad++;
                  $display("FAIL dump4 got acc_out=%h sat=%b cyc=%0d want acc_out=%h sat=%b cyc=%0d",
                           acc_out, sat_flag, cyc, e.d, e.s, e.c);
               end
            end
         end else if (sat_flag !== 1'b0) begin
            bad++;
            $display("FAIL sat_without_valid got sat=%b want 0", sat_flag);
         end
      end
   end

   always @(negedge clk) begin : mon1
      exp_t e;
      if (rst_n && out_valid1) begin
         total++;
         if (sb1.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse1 acc_out=%h", acc_out1);
         end else begin
            e = sb1.pop_front();
            if (acc_out1 !== e.d || sat_flag1 !== e.s || cyc !== e.c) begin
               bad++;
               $display("FAIL dump1 got acc_out=%h sat=%b cyc=%0d want acc_out=%h sat=%b cyc=%0d",
                        acc_out1, sat_flag1, cyc, e.d, e.s, e.c);
            end
         end
      end
   end

   function automatic exp_t ref_out(input longint s, input int c);
      longint r;
      exp_t   e;
      r = (s + 64'sd16384) / 64'sd32768;
      if ((s + 64'sd16384) < 0 && ((s + 64'sd16384) % 64'sd32768) != 0) r = r - 1;
      if (r > 32767)       begin e.d = 16'h7FFF; e.s = 1'b1; end
      else if (r < -32768) begin e.d = 16'h8000; e.s = 1'b1; end
      else                 begin e.d = 16'(r);   e.s = 1'b0; end
      e.c = c;
      return e;
   endfunction

   task automatic tap(input logic [31:0] p);
      @(posedge clk); #1;
      clear = 1'b0; prod_valid = 1'b1; product = p;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         clear = 1'b0; prod_valid = 1'b0; prod_valid1 = 1'b0;
      end
   endtask

   task automatic push(input logic [15:0] d, input logic s);
      sb.push_back('{d: d, s: s, c: cyc + 1});
   endtask

   task automatic drain;
      idle(3);
      total++;
      if (sb.size() != 0 || sb1.size() != 0) begin
         bad++;
         $display("FAIL missing_pulse pending4=%0d pending1=%0d want 0", sb.size(), sb1.size());
         sb.delete(); sb1.delete();
      end
   endtask

   task automatic four(input logic [31:0] p, input logic [15:0] d, input logic s);
      for (int i = 0; i < 4; i++) begin
         tap(p);
         if (i == 3) push(d, s);
      end
      idle(1);
   endtask

   task automatic test_reset;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (acc_out !== 16'h0 || out_valid !== 1'b0 || sat_flag !== 1'b0 || phase !== 2'd0) begin
         bad++;
         $display("FAIL reset got acc_out=%h ov=%b sat=%b ph=%0d want 0 0 0 0", acc_out, out_valid, sat_flag, phase);
      end
      total++;
      if (acc_out1 !== 16'h0 || out_valid1 !== 1'b0 || phase1 !== 1'b0) begin
         bad++;
         $display("FAIL reset1 got acc_out=%h ov=%b ph=%0d want 0 0 0", acc_out1, out_valid1, phase1);
      end
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   task automatic test_nominal;
      four(32'h0800_0000, 16'h4000, 1'b0);
      total++;
      if (phase !== 2'd0) begin
         bad++;
         $display("FAIL nominal_phase got %0d want 0", phase);
      end
      drain();
   endtask

   task automatic test_saturation;
      four(32'h1000_0000, 16'h7FFF, 1'b1);
      four(32'hC000_0000, 16'h8000, 1'b1);
      drain();
   endtask

   task automatic test_rounding;
      logic [31:0] pv [4];
      logic [15:0] ev [4];
      pv = '{32'h0000_4000, 32'hFFFF_C000, 32'h0000_3FFF, 32'hFFFF_BFFF};
      ev = '{16'h0001, 16'h0000, 16'h0000, 16'hFFFF};
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         prod_valid1 = 1'b1; product1 = pv[i];
         sb1.push_back('{d: ev[i], s: 1'b0, c: cyc + 1});
      end
      idle(1);
      total++;
      if (phase1 !== 1'b0) begin
         bad++;
         $display("FAIL taps1_phase got %0d want 0", phase1);
      end
      drain();
   endtask

   task automatic test_gapped;
      for (int i = 0; i < 4; i++) begin
         tap(32'h0800_0000);
         if (i == 3) push(16'h4000, 1'b0);
         else idle(i + 1);
      end
      drain();
   endtask

   task automatic test_clear;
      tap(32'h7000_0000);
      tap(32'h7000_0000);
      idle(1);
      total++;
      if (phase !== 2'd2) begin
         bad++;
         $display("FAIL phase_count got %0d want 2", phase);
      end
      @(posedge clk); #1 clear = 1'b1; prod_valid = 1'b0;
      idle(1);
      total++;
      if (phase !== 2'd0 || acc_out !== 16'h4000) begin
         bad++;
         $display("FAIL clear_state got ph=%0d acc_out=%h want 0 4000", phase, acc_out);
      end
      four(32'h0400_0000, 16'h2000, 1'b0);
      @(posedge clk); #1 clear = 1'b1; prod_valid = 1'b1; product = 32'h7FFF_FFFF;
      four(32'h0800_0000, 16'h4000, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tap(32'h0400_0000);
         if (i == 3) push(16'h2000, 1'b0);
      end
      @(posedge clk); #1 clear = 1'b1; prod_valid = 1'b0;
      drain();
   endtask

   task automatic test_mid_reset;
      tap(32'h0800_0000);
      tap(32'h0800_0000);
      tap(32'h0800_0000);
      @(posedge clk); #3;
      prod_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      total++;
      if (acc_out !== 16'h0 || out_valid !== 1'b0 || sat_flag !== 1'b0 || phase !== 2'd0) begin
         bad++;
         $display("FAIL async_reset got acc_out=%h ov=%b sat=%b ph=%0d want 0 0 0 0", acc_out, out_valid, sat_flag, phase);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      four(32'h0800_0000, 16'h4000, 1'b0);
      drain();
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 12; i++) begin
         tap((i % 2 == 0) ? 32'h0800_0000 : 32'hFC00_0000);
         if (i % 4 == 3) push(16'h1000, 1'b0);
      end
      drain();
   endtask

   task automatic test_random;
      longint      s;
      logic [31:0] p;
      for (int k = 0; k < 10; k++) begin
         s = 0;
         for (int i = 0; i < 4; i++) begin
            p = 32'($signed($urandom) >>> $urandom_range(0, 5));
            s = s + longint'($signed(p));
            tap(p);
            if (i == 3) sb.push_back(ref_out(s, cyc + 1));
            else idle($urandom_range(0, 2));
         end
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_saturation();
      test_rounding();
      test_gapped();
      test_clear();
      test_mid_reset();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/frac_dec_accumulator.md
Name: frac_dec_accumulator

Overview:
Accumulate-and-dump stage directly downstream of the fractional decimator's signed multiplier. It sums NUM_TAPS full-precision products per output sample in a guarded accumulator. At the end of each sample it rounds and saturates the sum back to DATA_WIDTH and emits one registered output with a valid pulse. It is the output stage of each polyphase filter branch.

Parameters:
DATA_WIDTH, 16, sample/coefficient width; product input is 2*DATA_WIDTH
NUM_TAPS, 4, products accumulated per output sample (>=1)
FRAC_BITS, 15, right-shift applied to the sum before output (Q30 to Q15)
GUARD_BITS, 8, extra accumulator MSBs; ACC_W = 2*DATA_WIDTH + GUARD_BITS

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous flush of the partial sum and the tap counter
prod_valid  input  1  product is valid this cycle
product  input  2*DATA_WIDTH  signed product from the multiplier
acc_out  output  DATA_WIDTH  signed rounded/saturated result, registered
out_valid  output  1  one-cycle pulse, acc_out updated
sat_flag  output  1  pulses with out_valid when the result was clipped
phase  output  clog2(NUM_TAPS) (min 1)  current tap index, debug/alignment

Behaviour:
- Reset (rst_n low, asynchronous): acc, phase, acc_out, out_valid and sat_flag all go to 0.
- Implicit 2-state FSM via phase:
  - IDLE: phase == 0, no partial sum.
  - ACCUM: phase in 1..NUM_TAPS-1.
- prod_valid=1, phase==0: acc <= sign_ext(product). Previous acc is discarded, so no dump-then-clear bubble.
- prod_valid=1, phase>0: acc <= acc + sign_ext(product).
- phase increments on each prod_valid and wraps from NUM_TAPS-1 to 0.
- prod_valid=0: acc and phase hold; gaps of any length are legal.
- Dump, when prod_valid=1 and phase==NUM_TAPS-1:
  - sum = (phase==0 ? 0 : acc) + sign_ext(product), full ACC_W width.
  - r = (sum + 2^(FRAC_BITS-1)) >>> FRAC_BITS. Arithmetic shift; round half toward +inf.
  - r > 2^(DATA_WIDTH-1)-1 gives 0x7FFF; r < -2^(DATA_WIDTH-1) gives 0x8000. Either case sets sat_flag=1.
  - acc_out, out_valid=1 and sat_flag are registered at the next edge.
- Latency: out_valid is high exactly 1 cycle after the cycle carrying the last tap.
- out_valid and sat_flag are 0 in every cycle not following a dump.
- acc_out holds its value between dumps.
- NUM_TAPS=1: every valid product dumps. phase stays 0.
- clear=1: phase <= 0, acc <= 0, no dump occurs.
  - clear has priority over a simultaneous prod_valid; that product is discarded.
  - A pending out_valid from the previous cycle's dump is still delivered.
  - acc_out is not altered.
- Overflow inside the accumulator is not detected. GUARD_BITS must cover log2(NUM_TAPS).
- No backpressure. The consumer must accept out_valid every time it pulses.

Test Plan:
1. Nominal: DW=16, FRAC_BITS=15, NUM_TAPS=4; four back-to-back products 0x0800_0000 -> one cycle after the 4th, out_valid=1 for one cycle, acc_out=0x4000, sat_flag=0; phase returns to 0.
2. Positive saturation: four products 0x1000_0000 (sum 0x4000_0000 -> r=0x8000) -> acc_out=0x7FFF, sat_flag=1. Negative: four products 0xC000_0000 -> acc_out=0x8000, sat_flag=1.
3. Rounding, one sample at NUM_TAPS=1:
   - product 0x0000_4000 -> acc_out=0x0001.
   - product 0xFFFF_C000 -> acc_out=0x0000.
   - product 0x0000_3FFF -> acc_out=0x0000.
   - product 0xFFFF_BFFF -> acc_out=0xFFFF.
4. Gapped input and clear:
   - Four 0x0800_0000 products with 0-3 idle cycles between them -> same 0x4000, still 1-cycle latency after the last tap.
   - Two taps, then clear, then four 0x0400_0000 -> acc_out=0x2000; the discarded taps have no effect.
   - clear asserted together with a prod_valid -> that product is ignored.
5. Reset mid-operation: rst_n low asynchronously after 3 taps -> all outputs 0 immediately, phase=0. After release, four 0x0800_0000 -> acc_out=0x4000.
6. Continuous stream: 12 consecutive valids alternating +0x0800_0000/-0x0400_0000 -> three out_valid pulses 4 cycles apart, each acc_out=0x1000, sat_flag=0.
